// File: rtl/memory_sdp_be_if.sv
// Write/read bus for memory_sdp_be: one byte-enabled write port and one read
// port with a valid-flagged return word; there is no backpressure in either direction.
interface memory_sdp_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  // Handshake: a request is taken on every clka edge where ena/enb is high;
  // doutb is meaningful only while doutb_valid is high, and there is no ready.
  logic                  ena;
  logic [DATA_W/8-1:0]   wea;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     dina;
  logic                  enb;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     doutb;
  logic                  doutb_valid;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  doutb, doutb_valid
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output doutb, doutb_valid
  );
endinterface

// File: rtl/memory_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables, write-first collision
// merging on the read port and an optional second output register.
module memory_sdp_be #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 9,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic            clka,
  input  logic            rstb,
  memory_sdp_be_if.slave  bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [DATA_W-1:0] RAM_INIT = (INIT_ZERO != 0) ? '0 : 'x;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $fatal(1, "memory_sdp_be: DATA_W must be a multiple of 8");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
    $fatal(1, "memory_sdp_be: ADDR_W too narrow for DEPTH");
  end

  logic [DATA_W-1:0] ram [DEPTH] = '{default: RAM_INIT};

  logic              wr_in_range;
  logic              rd_in_range;
  logic              collide;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;

  assign wr_in_range = ({1'b0, bus.addra} < DEPTH_L);
  assign rd_in_range = ({1'b0, bus.addrb} < DEPTH_L);
  assign collide     = bus.ena && wr_in_range && (bus.addra == bus.addrb);

  always_ff @(posedge clka) begin
    if (!rstb && bus.ena && wr_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i]) ram[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
      end
    end
  end

  // Out-of-range reads return zero; a same-address write wins byte-by-byte.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = ram[bus.addrb];
    merged = rd_word;
    if (collide) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i]) merged[8*i +: 8] = bus.dina[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_data_d  = '0;
    s1_valid_d = 1'b0;
    if (bus.enb) begin
      s1_data_d  = merged;
      s1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_valid_q;

    always_ff @(posedge clka) begin
      if (rstb) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s1_data_q;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign bus.doutb       = s2_data_q;
    assign bus.doutb_valid = s2_valid_q;
  end else begin : g_noreg
    assign bus.doutb       = s1_data_q;
    assign bus.doutb_valid = s1_valid_q;
  end
endmodule

// File: tb/tb_memory_sdp_be.sv
// Bench for memory_sdp_be: two instances (1- and 2-cycle latency, DEPTH=500)
// share one stimulus stream and are checked against a reference memory model.
module tb_memory_sdp_be;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 500;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [8:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [8:0]  addrb;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  memory_sdp_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  memory_sdp_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  memory_sdp_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(0), .INIT_ZERO(1))
    dut0 (.clka(clka), .rstb(rstb), .bus(bus0));
  memory_sdp_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(1), .INIT_ZERO(1))
    dut1 (.clka(clka), .rstb(rstb), .bus(bus1));

  // ---------------- scoreboard ----------------
  logic [DATA_W:0]   exp_q0[$];
  logic [DATA_W:0]   exp_q1[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got valid=%0b data=%08h, want valid=%0b data=%08h",
               name, act[DATA_W], act[DATA_W-1:0], exp[DATA_W], exp[DATA_W-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic [3:0] we, input logic [8:0] aa,
                      input logic [31:0] d, input logic eb, input logic [8:0] ab);
    logic [DATA_W:0] ent;
    rstb = r;
    bus0.ena = e;  bus0.wea = we; bus0.addra = aa; bus0.dina = d; bus0.enb = eb; bus0.addrb = ab;
    bus1.ena = e;  bus1.wea = we; bus1.addra = aa; bus1.dina = d; bus1.enb = eb; bus1.addrb = ab;
    @(posedge clka);
    if (!r && e && (int'(aa) < DEPTH)) begin
      for (int i = 0; i < 4; i++) if (we[i]) mdl[aa][8*i +: 8] = d[8*i +: 8];
    end
    if (r || !eb) ent = '0;
    else ent = {1'b1, (int'(ab) < DEPTH) ? mdl[ab] : 32'h0};
    exp_q0.push_back(ent);
    if (r) begin
      exp_q1.delete();
      exp_q1.push_back('0);
    end
    exp_q1.push_back(ent);
    #1;
    chk("sb_lat1", {bus0.doutb_valid, bus0.doutb}, exp_q0.pop_front());
    chk("sb_lat2", {bus1.doutb_valid, bus1.doutb}, exp_q1.pop_front());
  endtask

  function automatic vec_t mk(logic r, logic e, logic [3:0] we, logic [8:0] aa, logic [31:0] d,
                              logic eb, logic [8:0] ab, logic xv, logic [31:0] xd);
    vec_t v;
    v.rst = r; v.ena = e; v.wea = we; v.addra = aa; v.dina = d;
    v.enb = eb; v.addrb = ab; v.exp_v = xv; v.exp_d = xd;
    return v;
  endfunction

  // Rows: inputs for one edge, then the expected 1-cycle-latency output after it.
  vec_t tbl[17];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    bus0.ena = 0; bus0.wea = 0; bus0.addra = 0; bus0.dina = 0; bus0.enb = 0; bus0.addrb = 0;
    bus1.ena = 0; bus1.wea = 0; bus1.addra = 0; bus1.dina = 0; bus1.enb = 0; bus1.addrb = 0;

    tbl[0]  = mk(0, 1, 4'hF, 9'd5,   32'hAABBCCDD, 0, 9'd0,   0, 32'h0);
    tbl[1]  = mk(0, 1, 4'h5, 9'd5,   32'h11223344, 0, 9'd0,   0, 32'h0);
    tbl[2]  = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd5,   1, 32'hAA22CC44);
    tbl[3]  = mk(0, 1, 4'hF, 9'd7,   32'hFFFFFFFF, 0, 9'd0,   0, 32'h0);
    tbl[4]  = mk(0, 1, 4'h3, 9'd7,   32'h00001234, 1, 9'd7,   1, 32'hFFFF1234);
    tbl[5]  = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd7,   1, 32'hFFFF1234);
    tbl[6]  = mk(0, 1, 4'hF, 9'd510, 32'hDEADBEEF, 0, 9'd0,   0, 32'h0);
    tbl[7]  = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd510, 1, 32'h0);
    tbl[8]  = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd0,   1, 32'h0);
    tbl[9]  = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd10,  1, 32'h0);
    tbl[10] = mk(0, 1, 4'hF, 9'd499, 32'hCAFEF00D, 1, 9'd499, 1, 32'hCAFEF00D);
    tbl[11] = mk(0, 1, 4'hF, 9'd500, 32'h12345678, 1, 9'd0,   1, 32'h0);
    tbl[12] = mk(0, 1, 4'h0, 9'd5,   32'hFFFFFFFF, 1, 9'd5,   1, 32'hAA22CC44);
    tbl[13] = mk(1, 1, 4'hF, 9'd5,   32'h0,        1, 9'd5,   0, 32'h0);
    tbl[14] = mk(0, 0, 4'h0, 9'd0,   32'h0,        1, 9'd5,   1, 32'hAA22CC44);
    tbl[15] = mk(0, 1, 4'hC, 9'd500, 32'h55555555, 1, 9'd500, 1, 32'h0);
    tbl[16] = mk(0, 0, 4'h0, 9'd0,   32'h0,        0, 9'd0,   0, 32'h0);

    // Reset state
    step(1, 0, 4'h0, 9'd0, 32'h0, 1, 9'd0);
    chk("reset_lat1", {bus0.doutb_valid, bus0.doutb}, '0);
    chk("reset_lat2", {bus1.doutb_valid, bus1.doutb}, '0);

    // Table-driven vectors (byte enables, collision, out-of-range, reset retention)
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ena, tbl[i].wea, tbl[i].addra, tbl[i].dina, tbl[i].enb, tbl[i].addrb);
      chk($sformatf("vec%0d", i), {bus0.doutb_valid, bus0.doutb}, {tbl[i].exp_v, tbl[i].exp_d});
    end

    // Streaming with the 2-cycle instance
    for (int k = 0; k < 4; k++) step(0, 1, 4'hF, 9'(k), 32'h100 + k, 0, 9'd0);
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd0);
    chk("stream_lead", {bus1.doutb_valid, bus1.doutb}, '0);
    for (int k = 1; k < 5; k++) begin
      step(0, 0, 4'h0, 9'd0, 32'h0, (k < 4), 9'(k));
      chk($sformatf("stream%0d", k - 1), {bus1.doutb_valid, bus1.doutb}, {1'b1, 32'h100 + k - 1});
    end
    step(0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0);
    chk("stream_idle", {bus1.doutb_valid, bus1.doutb}, '0);

    // Reset flush of in-flight reads
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd1);
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd2);
    step(1, 0, 4'h0, 9'd0, 32'h0, 1, 9'd3);
    chk("flush_rst", {bus1.doutb_valid, bus1.doutb}, '0);
    step(0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0);
    chk("flush_nostale", {bus1.doutb_valid, bus1.doutb}, '0);
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd0);
    chk("flush_lead", {bus1.doutb_valid, bus1.doutb}, '0);
    step(0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0);
    chk("flush_retained", {bus1.doutb_valid, bus1.doutb}, {1'b1, 32'h100});

    // In-flight isolation
    step(0, 1, 4'hF, 9'd3, 32'h1, 0, 9'd0);
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd3);
    step(0, 1, 4'hF, 9'd3, 32'h2, 0, 9'd0);
    chk("inflight_old", {bus1.doutb_valid, bus1.doutb}, {1'b1, 32'h1});
    step(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd3);
    step(0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0);
    chk("inflight_new", {bus1.doutb_valid, bus1.doutb}, {1'b1, 32'h2});

    // Random traffic, scoreboard only
    for (int n = 0; n < 400; n++) begin
      logic [8:0] aa, ab;
      aa = 9'($urandom_range(0, 511));
      ab = ($urandom_range(0, 3) == 0) ? aa : 9'($urandom_range(0, 511));
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           aa, $urandom, 1'($urandom_range(0, 1)), ab);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
